// File: rtl/controle_multiciclo_nrisc_pkg.sv
// Shared nRISC control definitions: states, opcodes, ULA/pc_src/error codes.
package controle_multiciclo_nrisc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_STORE   = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_ALUR    = 3'b011;
    localparam logic [2:0] OP_ILLEGAL = 3'b100;
    localparam logic [2:0] OP_BEQ     = 3'b101;
    localparam logic [2:0] OP_JUMP    = 3'b110;
    localparam logic [2:0] OP_HALT    = 3'b111;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_IMM = 2'b01;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // ULA operation selected by the latched instruction
    function automatic logic [2:0] ula_op_for(input logic [2:0] op, input logic [1:0] fn);
        case (op)
            OP_ALUR: ula_op_for = {1'b0, fn};
            OP_BEQ:  ula_op_for = ULA_SUB;
            default: ula_op_for = ULA_ADD;
        endcase
    endfunction

    // Instructions whose second ULA operand is the immediate
    function automatic logic uses_imm(input logic [2:0] op);
        uses_imm = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/controle_multiciclo_nrisc_contador_espera.sv
// MEM-stage wait counter: counts cycles without mem_ready, flags the timeout limit.
module contador_espera #(
    parameter int unsigned LIMIT = 15,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal_c
);

    logic [W-1:0] count;

    assign terminal_c = (count == W'(LIMIT));

    // Clear on MEM entry, advance while memory is not ready, saturate at the limit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal_c) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/controle_multiciclo_nrisc.sv
// Multi-cycle nRISC sequencer: FETCH/DECODE/EXEC/MEM/WB with run/step, mem timeout, halt/illegal.
module controle_multiciclo_nrisc
    import controle_multiciclo_nrisc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic [2:0]       opcode,
    input  logic [1:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pcwrite,
    output logic [1:0]       pc_src,
    output logic             ulasrc,
    output logic [2:0]       ulaop,
    output logic             mem_req,
    output logic             memwrite,
    output logic             regsrc,
    output logic             regwrite,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [1:0]       error_code,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t     state, state_d;
    logic [2:0] op_q;
    logic [1:0] funct_q;
    logic [1:0] error_code_d;
    logic       retire;
    logic       wait_clear;
    logic       wait_en;
    logic       wait_done_c;

    contador_espera #(
        .LIMIT (MEM_TIMEOUT),
        .W     (WAIT_W)
    ) u_espera (
        .clock      (clock),
        .reset      (reset),
        .clear      (wait_clear),
        .enable     (wait_en),
        .terminal_c (wait_done_c)
    );

    assign busy   = (state != ST_IDLE) && (state != ST_HALT) && (state != ST_ERROR);
    assign halted = (state == ST_HALT);
    assign error  = (state == ST_ERROR);

    // State, latched instruction fields, error code and retired-instruction count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= OP_LOAD;
            funct_q     <= 2'b00;
            error_code  <= ERR_NONE;
            instr_count <= '0;
        end else begin
            state      <= state_d;
            error_code <= error_code_d;
            if (ir_write) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Next-state and datapath enables from state and latched opcode (zero only for BEQ in EXEC)
    always_comb begin
        state_d      = state;
        error_code_d = error_code;
        retire       = 1'b0;
        wait_clear   = 1'b0;
        wait_en      = 1'b0;
        ir_write     = 1'b0;
        pcwrite      = 1'b0;
        pc_src       = PC_INC;
        ulasrc       = 1'b0;
        ulaop        = ULA_ADD;
        mem_req      = 1'b0;
        memwrite     = 1'b0;
        regsrc       = 1'b0;
        regwrite     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_write = 1'b1;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                case (op_q)
                    OP_HALT:    state_d = ST_HALT;
                    OP_ILLEGAL: begin
                        state_d      = ST_ERROR;
                        error_code_d = ERR_ILLEGAL;
                    end
                    default:    state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                ulasrc = uses_imm(op_q);
                ulaop  = ula_op_for(op_q, funct_q);
                case (op_q)
                    OP_ADDI, OP_ALUR: state_d = ST_WB;
                    OP_LOAD, OP_STORE: begin
                        state_d    = ST_MEM;
                        wait_clear = 1'b1;
                    end
                    OP_BEQ: begin
                        pcwrite = 1'b1;
                        pc_src  = zero ? PC_IMM : PC_INC;
                        retire  = 1'b1;
                    end
                    OP_JUMP: begin
                        pcwrite = 1'b1;
                        pc_src  = PC_IMM;
                        retire  = 1'b1;
                    end
                    default: begin
                        state_d      = ST_ERROR;
                        error_code_d = ERR_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                ulasrc   = uses_imm(op_q);
                ulaop    = ula_op_for(op_q, funct_q);
                mem_req  = 1'b1;
                memwrite = (op_q == OP_STORE);
                if (mem_ready) begin
                    if (op_q == OP_STORE) begin
                        pcwrite = 1'b1;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_done_c) begin
                    state_d      = ST_ERROR;
                    error_code_d = ERR_TIMEOUT;
                end else begin
                    wait_en = 1'b1;
                end
            end
            ST_WB: begin
                ulasrc   = uses_imm(op_q);
                ulaop    = ula_op_for(op_q, funct_q);
                regwrite = 1'b1;
                regsrc   = (op_q == OP_LOAD);
                pcwrite  = 1'b1;
                retire   = 1'b1;
            end
            default: ;
        endcase
        if (retire) state_d = step_mode ? ST_IDLE : ST_FETCH;
    end

endmodule

// File: tb/tb_controle_multiciclo_nrisc.sv
// Self-checking bench: instruction-level schedule model expanded to per-cycle expected outputs.
module tb_controle_multiciclo_nrisc;

    localparam int unsigned MEM_TIMEOUT = 15;
    localparam int unsigned CNT_W       = 8;

    logic             clock;
    logic             reset;
    logic             start;
    logic             step_mode;
    logic [2:0]       opcode;
    logic [1:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             ir_write, pcwrite, ulasrc, mem_req, memwrite, regsrc, regwrite;
    logic             busy, halted, error;
    logic [1:0]       pc_src, error_code;
    logic [2:0]       ulaop;
    logic [CNT_W-1:0] instr_count;

    controle_multiciclo_nrisc #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .step_mode   (step_mode),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .ir_write    (ir_write),
        .pcwrite     (pcwrite),
        .pc_src      (pc_src),
        .ulasrc      (ulasrc),
        .ulaop       (ulaop),
        .mem_req     (mem_req),
        .memwrite    (memwrite),
        .regsrc      (regsrc),
        .regwrite    (regwrite),
        .busy        (busy),
        .halted      (halted),
        .error       (error),
        .error_code  (error_code),
        .instr_count (instr_count)
    );

    typedef struct packed {
        logic             ir_write;
        logic             pcwrite;
        logic [1:0]       pc_src;
        logic             ulasrc;
        logic [2:0]       ulaop;
        logic             mem_req;
        logic             memwrite;
        logic             regsrc;
        logic             regwrite;
        logic             busy;
        logic             halted;
        logic             error;
        logic [1:0]       error_code;
        logic [CNT_W-1:0] instr_count;
    } outs_t;

    typedef struct {
        logic       start;
        logic       step_mode;
        logic [2:0] opcode;
        logic [1:0] funct;
        logic       zero;
        logic       mem_ready;
        outs_t      exp;
        string      tag;
    } cyc_t;

    outs_t act;
    assign act = {ir_write, pcwrite, pc_src, ulasrc, ulaop, mem_req, memwrite,
                  regsrc, regwrite, busy, halted, error, error_code, instr_count};

    cyc_t       exp_q[$];
    cyc_t       cur;
    int         checks;
    int         failures;
    int         m_count;
    logic [1:0] m_err;
    int         mem_cycles;
    int         busy_cycles;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare DUT outputs against the scheduled expectation of each driven cycle
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if (act !== cur.exp) begin
                failures++;
                $display("FAIL %s: got %h want %h (t=%0t)", cur.tag, act, cur.exp, $time);
            end
            if (mem_req) mem_cycles++;
            if (busy) busy_cycles++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [2:0] ula_of(input logic [2:0] op, input logic [1:0] fn);
        if (op == 3'b011) return {1'b0, fn};
        if (op == 3'b101) return 3'b001;
        return 3'b000;
    endfunction

    // A cycle with random inputs and all-quiet expected outputs
    function automatic cyc_t base(input string tag);
        cyc_t c;
        c.start           = 1'($urandom);
        c.step_mode       = 1'($urandom);
        c.opcode          = 3'($urandom);
        c.funct           = 2'($urandom);
        c.zero            = 1'($urandom);
        c.mem_ready       = 1'($urandom);
        c.exp             = '0;
        c.exp.instr_count = CNT_W'(m_count);
        c.exp.error_code  = m_err;
        c.tag             = tag;
        return c;
    endfunction

    task automatic drive(input cyc_t c);
        start     = c.start;
        step_mode = c.step_mode;
        opcode    = c.opcode;
        funct     = c.funct;
        zero      = c.zero;
        mem_ready = c.mem_ready;
        exp_q.push_back(c);
        @(posedge clock);
        #1;
    endtask

    task automatic retire_cycle(input cyc_t c, input logic step);
        cyc_t r;
        r           = c;
        r.step_mode = step;
        drive(r);
        m_count = (m_count + 1) % (1 << CNT_W);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_lit("reset_outputs", 32'(act), 32'h0);
        @(posedge clock);
        #1;
        reset   = 1'b0;
        m_count = 0;
        m_err   = 2'b00;
    endtask

    task automatic start_from_idle();
        cyc_t c;
        int   n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            c       = base("idle");
            c.start = 1'b0;
            drive(c);
        end
        c       = base("idle_start");
        c.start = 1'b1;
        drive(c);
    endtask

    // Expand one instruction into its cycles; status 0 retired, 1 halted, 2 error
    task automatic run_instr(input logic [2:0] op, input logic [1:0] fn, input logic z,
                             input int waits, input logic step, output int status);
        cyc_t c;
        logic imm;
        imm    = (op == 3'b000) || (op == 3'b001) || (op == 3'b010);
        status = 0;
        c = base("fetch");
        c.exp.busy     = 1'b1;
        c.exp.ir_write = 1'b1;
        c.opcode       = op;
        c.funct        = fn;
        drive(c);
        c = base("decode");
        c.exp.busy = 1'b1;
        drive(c);
        if (op == 3'b111) begin
            status = 1;
            return;
        end
        if (op == 3'b100) begin
            m_err  = 2'b01;
            status = 2;
            return;
        end
        c = base("exec");
        c.exp.busy   = 1'b1;
        c.exp.ulasrc = imm;
        c.exp.ulaop  = ula_of(op, fn);
        if (op == 3'b101) begin
            c.zero        = z;
            c.exp.pcwrite = 1'b1;
            c.exp.pc_src  = {1'b0, z};
            retire_cycle(c, step);
            return;
        end
        if (op == 3'b110) begin
            c.exp.pcwrite = 1'b1;
            c.exp.pc_src  = 2'b01;
            retire_cycle(c, step);
            return;
        end
        drive(c);
        if (op == 3'b000 || op == 3'b001) begin
            for (int i = 0; i <= int'(MEM_TIMEOUT); i++) begin
                c = base("mem");
                c.exp.busy     = 1'b1;
                c.exp.ulasrc   = imm;
                c.exp.ulaop    = ula_of(op, fn);
                c.exp.mem_req  = 1'b1;
                c.exp.memwrite = (op == 3'b001);
                c.mem_ready    = (i == waits);
                if (i == waits) begin
                    if (op == 3'b001) begin
                        c.exp.pcwrite = 1'b1;
                        retire_cycle(c, step);
                        return;
                    end
                    drive(c);
                    break;
                end
                drive(c);
                if (i == int'(MEM_TIMEOUT)) begin
                    m_err  = 2'b10;
                    status = 2;
                    return;
                end
            end
        end
        c = base("wb");
        c.exp.busy     = 1'b1;
        c.exp.ulasrc   = imm;
        c.exp.ulaop    = ula_of(op, fn);
        c.exp.regwrite = 1'b1;
        c.exp.regsrc   = (op == 3'b000);
        c.exp.pcwrite  = 1'b1;
        retire_cycle(c, step);
    endtask

    task automatic absorb(input int n, input logic is_halt);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = base(is_halt ? "halt_hold" : "error_hold");
            if (i == 0) c.start = 1'b1;
            c.exp.halted = is_halt;
            c.exp.error  = !is_halt;
            drive(c);
        end
    endtask

    initial begin
        int         st;
        int         b0, m0;
        logic [2:0] legal [6];
        logic [2:0] op;
        logic       step;
        cyc_t       c;
        legal = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110};
        checks = 0; failures = 0; m_count = 0; m_err = 2'b00;
        mem_cycles = 0; busy_cycles = 0;
        start = 0; step_mode = 0; opcode = 0; funct = 0; zero = 0; mem_ready = 0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        do_reset();

        // ADDI single step
        start_from_idle();
        b0 = busy_cycles;
        run_instr(3'b010, 2'b00, 1'b0, 0, 1'b1, st);
        check_lit("addi_latency", 32'(busy_cycles - b0), 32'd4);
        check_lit("addi_count", 32'(instr_count), 32'd1);

        // LOAD with three not-ready cycles
        start_from_idle();
        b0 = busy_cycles; m0 = mem_cycles;
        run_instr(3'b000, 2'b00, 1'b0, 3, 1'b1, st);
        check_lit("load_mem_cycles", 32'(mem_cycles - m0), 32'd4);
        check_lit("load_latency", 32'(busy_cycles - b0), 32'd8);

        // Branches and jump
        start_from_idle();
        b0 = busy_cycles;
        run_instr(3'b101, 2'b00, 1'b1, 0, 1'b1, st);
        check_lit("beq_latency", 32'(busy_cycles - b0), 32'd3);
        start_from_idle();
        run_instr(3'b101, 2'b00, 1'b0, 0, 1'b1, st);
        start_from_idle();
        run_instr(3'b110, 2'b00, 1'b0, 0, 1'b1, st);
        start_from_idle();
        b0 = busy_cycles;
        run_instr(3'b001, 2'b00, 1'b0, 0, 1'b1, st);
        check_lit("store_latency", 32'(busy_cycles - b0), 32'd4);

        // Step mode over three ALU-R instructions
        do_reset();
        for (int i = 0; i < 3; i++) begin
            start_from_idle();
            run_instr(3'b011, 2'($urandom), 1'b0, 0, 1'b1, st);
        end
        check_lit("step_count", 32'(instr_count), 32'd3);

        // Randomised stream, wraps the retired counter
        do_reset();
        start_from_idle();
        for (int i = 0; i < 300; i++) begin
            op   = legal[$urandom_range(0, 5)];
            step = ($urandom_range(0, 3) == 0);
            run_instr(op, 2'($urandom), 1'($urandom),
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MEM_TIMEOUT))
                                                  : int'($urandom_range(0, 3)),
                      step, st);
            if (step) start_from_idle();
        end
        check_lit("random_count_wrap", 32'(instr_count), 32'd44);

        // STORE timeout
        do_reset();
        start_from_idle();
        m0 = mem_cycles;
        run_instr(3'b001, 2'b00, 1'b0, 1000, 1'b0, st);
        check_lit("timeout_status", 32'(st), 32'd2);
        absorb(4, 1'b0);
        check_lit("timeout_mem_cycles", 32'(mem_cycles - m0), 32'd16);
        check_lit("timeout_code", 32'(error_code), 32'd2);
        check_lit("timeout_busy", 32'(busy), 32'd0);
        do_reset();
        check_lit("timeout_cleared", 32'(error_code), 32'd0);

        // Illegal opcode
        start_from_idle();
        run_instr(3'b100, 2'b00, 1'b0, 0, 1'b0, st);
        absorb(3, 1'b0);
        check_lit("illegal_code", 32'(error_code), 32'd1);

        // HALT keeps the retired count
        do_reset();
        start_from_idle();
        run_instr(3'b010, 2'b01, 1'b0, 0, 1'b0, st);
        run_instr(3'b111, 2'b00, 1'b0, 0, 1'b0, st);
        absorb(3, 1'b1);
        check_lit("halt_count", 32'(instr_count), 32'd1);
        check_lit("halt_flag", 32'(halted), 32'd1);

        // Reset asserted during EXEC of an ADDI
        do_reset();
        start_from_idle();
        c = base("fetch_r");
        c.exp.busy = 1'b1; c.exp.ir_write = 1'b1; c.opcode = 3'b010;
        drive(c);
        c = base("decode_r");
        c.exp.busy = 1'b1;
        drive(c);
        check_lit("exec_before_reset", 32'({busy, ulasrc}), 32'd3);
        reset = 1'b1;
        #1;
        check_lit("reset_in_exec", 32'(act), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0; m_count = 0; m_err = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
